// File: rtl/f8_uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter on the f8 data bus: byte-lane decoded
// 8-byte register window, TX FIFO and serializer.
module f8_uart_tx_periph #(
    parameter logic [15:0] BASE       = 16'hFF00,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dread_addr,
    output logic [15:0] dread_data,
    output logic        dread_hit,
    input  logic [15:0] dwrite_addr,
    input  logic [15:0] dwrite_data,
    input  logic [1:0]  dwrite_en,
    output logic        tx,
    output logic        irq
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e        state_q, state_d;
    logic [15:0]   div_q, div_d, cnt_q, cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [2:0]    bit_q, bit_d;
    logic          tx_q, tx_d;
    logic          en_q, en_d, ien_q, ien_d, ovf_q, ovf_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [CW-1:0] count_q, count_d;
    logic          full, empty, busy, pop, push, push_ok, ovf_clr;
    logic [7:0]    push_byte;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign busy    = (state_q != S_IDLE);
    assign push_ok = push & ~full;
    assign count_d = count_q + CW'(push_ok) - CW'(pop);
    assign tx      = tx_q;
    assign irq     = ien_q & empty & ~busy;

    function automatic logic in_win(input logic [15:0] a);
        return a[15:3] == BASE[15:3];
    endfunction

    // Read mux: each byte lane decoded on its own, address+1 wraps naturally.
    always_comb begin
        logic [15:0] a;
        logic [7:0]  rb;
        dread_data = '0;
        dread_hit  = 1'b0;
        for (int l = 0; l < 2; l++) begin
            a  = dread_addr + 16'(l);
            rb = '0;
            if (in_win(a)) begin
                dread_hit = 1'b1;
                case (a[2:0])
                    3'd1:    rb = {4'b0, ovf_q, busy, empty, full};
                    3'd2:    rb = div_q[7:0];
                    3'd3:    rb = div_q[15:8];
                    3'd4:    rb = {6'b0, ien_q, en_q};
                    default: rb = '0;
                endcase
            end
            dread_data[8*l +: 8] = rb;
        end
    end

    // Write decode; an OVF clear in the same write beats an overflow set.
    always_comb begin
        logic [15:0] a;
        logic [7:0]  wb;
        div_d     = div_q;
        en_d      = en_q;
        ien_d     = ien_q;
        push      = 1'b0;
        push_byte = '0;
        ovf_clr   = 1'b0;
        for (int l = 0; l < 2; l++) begin
            a  = dwrite_addr + 16'(l);
            wb = dwrite_data[8*l +: 8];
            if (dwrite_en[l] && in_win(a)) begin
                case (a[2:0])
                    3'd0: begin push = 1'b1; push_byte = wb; end
                    3'd1: ovf_clr = wb[3];
                    3'd2: div_d[7:0] = wb;
                    3'd3: div_d[15:8] = wb;
                    3'd4: begin en_d = wb[0]; ien_d = wb[1]; end
                    default: ;
                endcase
            end
        end
        ovf_d = ovf_q;
        if (push && full) ovf_d = 1'b1;
        if (ovf_clr)      ovf_d = 1'b0;
    end

    // Serializer next state; the bit counter reloads from the live divider.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (en_q && !empty) begin
                    state_d = S_START;
                    pop     = 1'b1;
                    shreg_d = mem_q[rp_q];
                    cnt_d   = div_q;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                    cnt_d   = div_q;
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = div_q;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    if (en_q && !empty) begin
                        state_d = S_START;
                        pop     = 1'b1;
                        shreg_d = mem_q[rp_q];
                        cnt_d   = div_q;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            div_q   <= DIV_RESET;
            en_q    <= 1'b0;
            ien_q   <= 1'b0;
            ovf_q   <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            div_q   <= div_d;
            en_q    <= en_d;
            ien_q   <= ien_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            if (push_ok) wp_q <= wp_q + PW'(1);
            if (pop)     rp_q <= rp_q + PW'(1);
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wp_q] <= push_byte;
    end

endmodule

// File: tb/tb_f8_uart_tx_periph.sv
// Directed bench for f8_uart_tx_periph: register reads, frame waveforms,
// FIFO overflow, byte-lane decode, async reset and irq timing.
module tb_f8_uart_tx_periph;
    localparam logic [15:0] BASE  = 16'hFF00;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] dread_addr;
    logic [15:0] dread_data;
    logic        dread_hit;
    logic [15:0] dwrite_addr;
    logic [15:0] dwrite_data;
    logic [1:0]  dwrite_en;
    logic        tx;
    logic        irq;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [7:0]  sb [$];
    logic [15:0] rdata;
    logic        rhit;
    logic        exp_ovf = 1'b0;

    always #5 clk = ~clk;

    f8_uart_tx_periph #(.BASE(BASE), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'd9)) dut (
        .clk(clk), .reset(reset),
        .dread_addr(dread_addr), .dread_data(dread_data), .dread_hit(dread_hit),
        .dwrite_addr(dwrite_addr), .dwrite_data(dwrite_data), .dwrite_en(dwrite_en),
        .tx(tx), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] e);
        @(negedge clk);
        dwrite_addr = a;
        dwrite_data = d;
        dwrite_en   = e;
        @(negedge clk);
        dwrite_en   = 2'b00;
    endtask

    task automatic rd(input logic [15:0] a);
        dread_addr = a;
        #1;
        rdata = dread_data;
        rhit  = dread_hit;
    endtask

    task automatic push_sb(input logic [7:0] b);
        if (sb.size() < DEPTH) sb.push_back(b);
        else exp_ovf = 1'b1;
        wr(BASE, {8'h00, b}, 2'b01);
    endtask

    // Receive one frame sampling mid-bit; n = clocks per bit.
    task automatic recv_frame(input int n, input bit check_gap);
        int         w;
        logic [7:0] b;
        logic [7:0] exp;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (tx !== 1'b0 && w < 2000);
        if (tx !== 1'b0) begin
            chk("frame_start_timeout", 32'(tx), 32'd0);
            return;
        end
        if (check_gap) chk("no_idle_gap", 32'(w), 32'(n / 2));
        repeat (n / 2) @(negedge clk);
        chk("start_bit", 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (n) @(negedge clk);
            b[i] = tx;
        end
        repeat (n) @(negedge clk);
        chk("stop_bit", 32'(tx), 32'd1);
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        chk("frame_data", 32'(b), 32'(exp));
    endtask

    initial begin
        logic [9:0] fr;
        int         w;
        logic       saw_low;

        reset       = 1'b0;
        dread_addr  = BASE + 16'd1;
        dwrite_addr = '0;
        dwrite_data = '0;
        dwrite_en   = 2'b00;
        repeat (2) @(negedge clk);

        // Reset values, read while reset is held
        rd(BASE + 16'd1);
        chk("rst_hit_b1", 32'(rhit), 32'd1);
        chk("rst_word_b1", 32'(rdata), 32'h0902);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        rd(BASE + 16'd2);
        chk("rst_div", 32'(rdata), 32'h0009);
        rd(16'h1234);
        chk("outside_hit", 32'(rhit), 32'd0);
        chk("outside_data", 32'(rdata), 32'd0);
        rd(BASE + 16'd7);
        chk("edge_b7_hit", 32'(rhit), 32'd1);
        chk("edge_b7_data", 32'(rdata), 32'd0);

        @(negedge clk);
        reset = 1'b1;

        // Single transmit of A5 with DIV=3, exact waveform
        wr(BASE + 16'd2, 16'h0003, 2'b11);
        wr(BASE + 16'd4, 16'h0001, 2'b01);
        rd(BASE + 16'd2);
        chk("div_rw", 32'(rdata), 32'h0003);
        rd(BASE + 16'd4);
        chk("ctrl_rw", 32'(rdata), 32'h0001);
        wr(BASE, 16'h00A5, 2'b01);
        chk("tx_before_start", 32'(tx), 32'd1);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk($sformatf("a5_bit%0d", k / 4), 32'(tx), 32'(fr[k / 4]));
        end
        @(negedge clk);
        chk("a5_idle_tx", 32'(tx), 32'd1);
        rd(BASE + 16'd1);
        chk("a5_status", 32'(rdata), 32'h0302);
        chk("a5_irq", 32'(irq), 32'd0);

        // FIFO fill and overflow with EN=0, then drain back-to-back
        wr(BASE + 16'd4, 16'h0000, 2'b01);
        push_sb(8'h11);
        push_sb(8'h22);
        push_sb(8'h33);
        push_sb(8'h44);
        rd(BASE + 16'd1);
        chk("fifo_full_status", 32'(rdata), 32'h0301);
        push_sb(8'h55);
        rd(BASE + 16'd1);
        chk("ovf_status", 32'(rdata), {16'h0, 8'h03, 4'h0, exp_ovf, 3'b001});
        wr(BASE + 16'd4, 16'h0001, 2'b01);
        recv_frame(4, 1'b0);
        recv_frame(4, 1'b1);
        recv_frame(4, 1'b1);
        recv_frame(4, 1'b1);
        repeat (3) @(negedge clk);
        rd(BASE + 16'd1);
        chk("drained_status", 32'(rdata), 32'h030A);
        wr(BASE + 16'd1, 16'h0008, 2'b01);
        rd(BASE + 16'd1);
        chk("ovf_cleared", 32'(rdata), 32'h0302);

        // High-lane-only word write at BASE-1 pushes TXDATA
        sb.push_back(8'h4C);
        wr(BASE - 16'd1, 16'h4C00, 2'b10);
        rd(BASE - 16'd1);
        chk("lane_hit", 32'(rhit), 32'd1);
        chk("lane_data", 32'(rdata), 32'd0);
        recv_frame(4, 1'b0);
        repeat (4) @(negedge clk);

        // Async reset during data bit 3 of C3
        wr(BASE, 16'h00C3, 2'b01);
        repeat (18) @(negedge clk);
        chk("c3_bit3_low", 32'(tx), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("tx_async_reset", 32'(tx), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rd(BASE + 16'd1);
        chk("post_reset_status", 32'(rdata), 32'h0902);
        saw_low = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx !== 1'b1) saw_low = 1'b1;
        end
        chk("no_frame_after_reset", 32'(saw_low), 32'd0);

        // IRQ timing, DIV back at reset value 9
        wr(BASE + 16'd4, 16'h0003, 2'b01);
        chk("irq_idle_empty", 32'(irq), 32'd1);
        wr(BASE, 16'h005A, 2'b01);
        chk("irq_drop_push", 32'(irq), 32'd0);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (irq !== 1'b1 && w < 300);
        chk("irq_rise_cycle", 32'(w), 32'd101);
        rd(BASE + 16'd1);
        chk("irq_idle_status", 32'(rdata), 32'h0902);
        wr(BASE, 16'h00A1, 2'b01);
        chk("irq_drop_push2", 32'(irq), 32'd0);
        @(negedge clk);
        rd(BASE + 16'd1);
        chk("busy_status", 32'(rdata), 32'h0906);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
